// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, variable-latency memory between the instruction
// fetch port (IF) and the data memory port (DM) of the CPU pipeline.
// Only one access is in flight at a time. Each access walks
// IDLE -> GRANT -> RESP -> IDLE, so the fastest access takes 3 cycles.
//
// In IDLE the arbiter picks a winner. The data port normally wins a tie.
// A fetch starved by MAX_DM_STREAK back-to-back data grants wins the next tie.
// The memory request is frozen for the whole GRANT state. The completion is
// returned as a one-cycle acknowledge together with registered read data.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   if_req/if_addr      fetch request (held until if_ack) and its address
//   if_ack/if_rdata     one-cycle fetch completion and the fetched word
//   dm_req/dm_we/...    data request, write enable, address, write data
//   dm_ack/dm_rdata     one-cycle data completion and the read data
//   mem_*               memory-side request; mem_ready completes an access
//   busy                high whenever the sequencer is not IDLE
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int MAX_DM_STREAK = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,

    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t              state_q,     state_d;
    logic [3:0]          streak_q,    streak_d;
    logic                grant_dm_q,  grant_dm_d;   // 1: current access belongs to DM
    logic                mem_req_q,   mem_req_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                if_ack_q,    if_ack_d;
    logic                dm_ack_q,    dm_ack_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q,  dm_rdata_d;
    logic                busy_q,      busy_d;

    // A fetch that has already waited through a full data streak takes the
    // tie. Otherwise the data port wins, because stalling MEM also stalls IF.
    logic fetch_starved;
    logic dm_wins;

    assign fetch_starved = if_req && (streak_q >= STREAK_MAX);
    assign dm_wins       = dm_req && !fetch_starved;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        grant_dm_d  = grant_dm_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;         // acks are single-cycle pulses
        dm_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        busy_d      = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (if_req || dm_req) begin
                    state_d   = ST_GRANT;
                    mem_req_d = 1'b1;
                    busy_d    = 1'b1;
                    if (dm_wins) begin
                        grant_dm_d = 1'b1;
                        mem_addr_d = dm_addr;
                        mem_we_d   = dm_we;
                        if (dm_we) begin
                            mem_wdata_d = dm_wdata;
                        end
                        // Count only grants that made a fetch wait.
                        // An uncontested data grant resets the streak.
                        if (if_req) begin
                            streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX
                                                                : streak_q + 4'd1;
                        end else begin
                            streak_d = 4'd0;
                        end
                    end else begin
                        grant_dm_d = 1'b0;
                        mem_addr_d = if_addr;
                        mem_we_d   = 1'b0;
                        streak_d   = 4'd0;
                    end
                end
            end

            ST_GRANT: begin
                // The memory request is frozen here. Requester inputs are
                // ignored until the memory completes.
                if (mem_ready) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (grant_dm_q) begin
                        dm_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            dm_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end

            ST_RESP: begin
                // The requester sees its ack this cycle and drops or updates
                // its request. Arbitration resumes in the following IDLE cycle.
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers. Reset abandons any access in flight, and no ack follows.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            streak_q    <= 4'd0;
            grant_dm_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            grant_dm_q  <= grant_dm_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_ack    = dm_ack_q;
    assign dm_rdata  = dm_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Stimulus tasks drive the requesters. Before each access they push the
// expected memory-side request onto gq and the expected acknowledge onto aq.
// A separate monitor pops those queues whenever the DUT raises mem_req or an
// ack, and compares the result. A small responder model plays the memory.
// It raises mem_ready after a programmable number of wait cycles.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;

    mem_port_arbiter #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .MAX_DM_STREAK (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } grant_t;

    typedef struct {
        logic        is_dm;
        logic [31:0] data;
    } ack_t;

    grant_t      gq[$];
    ack_t        aq[$];
    int          checks = 0;
    int          errors = 0;
    int          lat    = 0;
    logic [31:0] rd_val = 32'h0;
    logic [31:0] exp_dm_rdata = 32'h0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    initial begin
        int cnt;
        cnt       = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (cnt >= lat) begin
                    mem_ready = 1'b1;
                end else begin
                    mem_ready = 1'b0;
                    cnt++;
                end
            end else begin
                mem_ready = 1'b0;
                cnt       = 0;
            end
            mem_rdata = rd_val;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic   mem_req_prev;
        logic   have_g;
        grant_t cur_g;
        ack_t   e;
        mem_req_prev = 1'b0;
        have_g       = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req && !mem_req_prev) begin
                if (gq.size() == 0) begin
                    checks++;
                    errors++;
                    have_g = 1'b0;
                    $display("FAIL unexpected_grant actual=addr %h required=no grant", mem_addr);
                end else begin
                    cur_g  = gq.pop_front();
                    have_g = 1'b1;
                    $display("grant addr=%h we=%b wdata=%h", mem_addr, mem_we, mem_wdata);
                end
            end
            if (mem_req && have_g) begin
                chk32("mem_addr", mem_addr, cur_g.addr);
                chk1("mem_we", mem_we, cur_g.we);
                if (cur_g.we) chk32("mem_wdata", mem_wdata, cur_g.wdata);
            end
            chk1("mem_we_without_req", mem_we & ~mem_req, 1'b0);
            chk1("busy", busy, mem_req | if_ack | dm_ack);
            chk1("dual_ack", if_ack & dm_ack, 1'b0);
            if (if_ack || dm_ack) begin
                if (aq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack actual=if_ack %b dm_ack %b required=no ack", if_ack, dm_ack);
                end else begin
                    e = aq.pop_front();
                    chk1("ack_port_is_dm", dm_ack, e.is_dm);
                    if (e.is_dm) chk32("dm_rdata", dm_rdata, e.data);
                    else         chk32("if_rdata", if_rdata, e.data);
                    $display("ack port=%s if_rdata=%h dm_rdata=%h",
                             dm_ack ? "DM" : "IF", if_rdata, dm_rdata);
                end
            end
            mem_req_prev = mem_req;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_exp(input logic is_dm, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rdv);
        grant_t g;
        ack_t   a;
        g.addr  = addr;
        g.we    = is_dm & we;
        g.wdata = wd;
        gq.push_back(g);
        if (is_dm && !we) exp_dm_rdata = rdv;
        a.is_dm = is_dm;
        a.data  = is_dm ? exp_dm_rdata : rdv;
        aq.push_back(a);
    endtask

    // One isolated access. Counts mem_req and busy cycles until the ack.
    // The data write value is toggled mid-access to prove it was latched.
    task automatic single(input logic is_dm, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rdv, input int latency,
                          output int nreq, output int nbusy, output logic got);
        lat    = latency;
        rd_val = rdv;
        push_exp(is_dm, we, addr, wd, rdv);
        @(negedge clk);
        if (is_dm) begin
            dm_addr  = addr;
            dm_we    = we;
            dm_wdata = wd;
            dm_req   = 1'b1;
        end else begin
            if_addr = addr;
            if_req  = 1'b1;
        end
        nreq  = 0;
        nbusy = 0;
        got   = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            nreq  += int'(mem_req);
            nbusy += int'(busy);
            if (c == 2) dm_wdata = ~dm_wdata;
            if (if_ack || dm_ack) got = 1'b1;
        end
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    // Both ports requesting. if_req can be dropped and raised after given acks.
    task automatic stream(input int total, input int drop_if_at, input int raise_if_at,
                          output int cnt);
        cnt = 0;
        @(negedge clk);
        if_req = 1'b1;
        dm_req = 1'b1;
        for (int c = 0; c < 400 && cnt < total; c++) begin
            @(negedge clk);
            if (if_ack || dm_ack) begin
                cnt++;
                if (cnt == drop_if_at)  if_req = 1'b0;
                if (cnt == raise_if_at) if_req = 1'b1;
                if (cnt == total) begin
                    if_req = 1'b0;
                    dm_req = 1'b0;
                end
            end
        end
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   nreq;
        int   nbusy;
        int   cnt;
        logic got;
        string order;

        rst      = 1'b1;
        if_req   = 1'b0;
        if_addr  = 32'h0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = 32'h0;
        dm_wdata = 32'h0;

        // Reset values are present without any clock edge.
        #3;
        chk1 ("rst_mem_req",   mem_req,   1'b0);
        chk1 ("rst_mem_we",    mem_we,    1'b0);
        chk32("rst_mem_addr",  mem_addr,  32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk1 ("rst_if_ack",    if_ack,    1'b0);
        chk1 ("rst_dm_ack",    dm_ack,    1'b0);
        chk32("rst_if_rdata",  if_rdata,  32'h0);
        chk32("rst_dm_rdata",  dm_rdata,  32'h0);
        chk1 ("rst_busy",      busy,      1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single fetch with a zero-latency memory.
        single(1'b0, 1'b0, 32'h40, 32'h0, 32'h2402000A, 0, nreq, nbusy, got);
        chk1 ("t1_ack_seen",       got,   1'b1);
        chk32("t1_mem_req_cycles", nreq,  32'd1);
        chk32("t1_busy_cycles",    nbusy, 32'd2);
        @(negedge clk);
        chk32("t1_if_rdata_held",  if_rdata, 32'h2402000A);
        chk1 ("t1_back_idle",      busy,     1'b0);

        // Data write with 4 wait cycles. dm_rdata must not take the memory value.
        single(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 32'hCAFEF00D, 4, nreq, nbusy, got);
        chk1 ("t2_ack_seen",       got,   1'b1);
        chk32("t2_mem_req_cycles", nreq,  32'd5);
        chk32("t2_busy_cycles",    nbusy, 32'd6);
        @(negedge clk);
        chk32("t2_dm_rdata_kept",  dm_rdata, 32'h0);

        // Continuous contention: D D D I D D D I.
        lat      = 0;
        rd_val   = 32'h11112222;
        if_addr  = 32'h100;
        dm_addr  = 32'h200;
        dm_we    = 1'b0;
        order    = "DDDIDDDI";
        for (int i = 0; i < 8; i++) begin
            if (order[i] == "D") push_exp(1'b1, 1'b0, 32'h200, 32'h0, 32'h11112222);
            else                 push_exp(1'b0, 1'b0, 32'h100, 32'h0, 32'h11112222);
        end
        stream(8, 0, 0, cnt);
        chk32("t3_ack_count", cnt, 32'd8);
        repeat (2) @(negedge clk);

        // if_req drops after two data grants, so the next data grant is
        // uncontested and clears the streak. After if_req returns, three
        // more data grants precede the fetch: D D D D D D I.
        rd_val = 32'h33334444;
        order  = "DDDDDDI";
        for (int i = 0; i < 7; i++) begin
            if (order[i] == "D") push_exp(1'b1, 1'b0, 32'h200, 32'h0, 32'h33334444);
            else                 push_exp(1'b0, 1'b0, 32'h100, 32'h0, 32'h33334444);
        end
        stream(7, 2, 3, cnt);
        chk32("t4_ack_count", cnt, 32'd7);
        repeat (3) @(negedge clk);
        chk32("t4_no_extra_grant", 32'(gq.size()), 32'd0);

        // Reset while in GRANT. Outputs clear at once, and the held request
        // restarts from IDLE and yields exactly one ack.
        lat     = 20;
        rd_val  = 32'h55556666;
        dm_we   = 1'b0;
        dm_addr = 32'h80;
        begin
            grant_t g;
            g.addr  = 32'h80;
            g.we    = 1'b0;
            g.wdata = 32'h0;
            gq.push_back(g);
        end
        @(negedge clk);
        dm_req = 1'b1;
        got    = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (mem_req) got = 1'b1;
        end
        chk1("t5_grant_seen", got, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk1 ("t5_rst_mem_req",  mem_req,  1'b0);
        chk1 ("t5_rst_busy",     busy,     1'b0);
        chk32("t5_rst_mem_addr", mem_addr, 32'h0);
        chk32("t5_rst_if_rdata", if_rdata, 32'h0);
        chk1 ("t5_rst_dm_ack",   dm_ack,   1'b0);
        exp_dm_rdata = 32'h0;
        lat = 2;
        push_exp(1'b1, 1'b0, 32'h80, 32'h0, 32'h55556666);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (dm_ack) begin
                cnt++;
                dm_req = 1'b0;
            end
        end
        dm_req = 1'b0;
        chk32("t5_ack_count", cnt, 32'd1);

        // Request held through RESP gives two distinct accesses.
        lat     = 1;
        rd_val  = 32'h77778888;
        dm_addr = 32'h300;
        push_exp(1'b1, 1'b0, 32'h300, 32'h0, 32'h77778888);
        push_exp(1'b1, 1'b0, 32'h300, 32'h0, 32'h9999AAAA);
        @(negedge clk);
        dm_req = 1'b1;
        cnt    = 0;
        for (int c = 0; c < 40 && cnt < 2; c++) begin
            @(negedge clk);
            if (dm_ack) begin
                cnt++;
                if (cnt == 1) rd_val = 32'h9999AAAA;
                if (cnt == 2) dm_req = 1'b0;
            end
        end
        dm_req = 1'b0;
        chk32("t6_ack_count", cnt, 32'd2);

        repeat (5) @(negedge clk);
        chk32("grants_left", 32'(gq.size()), 32'd0);
        chk32("acks_left",   32'(aq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
